// File: rtl/twos_serial_ctrl.sv
// -----------------------------------------------------------------------------
// twos_serial_ctrl
//   Nibble-serial increment / two's-complement negate engine. A single shared
//   4-bit incrementer slice is reused once per nibble, LSB nibble first. Negate
//   is formed as ~A + 1: the operand is inverted on accept and then fed through
//   the same increment path as a plain increment.
//
//   WIDTH must be a multiple of 4 and at least 8; NIB = WIDTH/4 cycles of work.
//   Accept at edge 0 -> out_valid high after edge NIB.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   requester presents an operation
//   in_ready   out  block idle and able to accept
//   op         in   0 = increment (A+1), 1 = negate (~A+1)
//   a          in   operand, sampled on accept
//   out_valid  out  result / cout / ovf valid
//   out_ready  in   consumer takes the result
//   result     out  computed word
//   cout       out  carry out of the final nibble
//   ovf        out  signed overflow
//   busy       out  high whenever not idle
// -----------------------------------------------------------------------------
module twos_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  operand_r;
  logic [WIDTH-1:0]  result_r;
  logic [IDXW-1:0]   idx_r;
  logic              carry_r;
  logic              op_r;
  logic              amsb_r;
  logic              cout_r;
  logic              ovf_r;

  logic [3:0]        nib_s;
  logic [4:0]        slice_s;
  logic              ovf_s;

  // Shared 4-bit incrementer slice: {carry, sum} = b + cin.
  function automatic logic [4:0] inc_slice(input logic [3:0] b, input logic cin);
    inc_slice = {1'b0, b} + {4'b0000, cin};
  endfunction

  // Select the current operand nibble, run it through the slice and form the
  // overflow flag from the sign bit the final nibble is about to produce.
  always_comb begin
    nib_s   = operand_r[{idx_r, 2'b00} +: 4];
    slice_s = inc_slice(nib_s, carry_r);
    ovf_s   = (~op_r & ~amsb_r & slice_s[3]) | (op_r & amsb_r & slice_s[3]);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      operand_r <= {WIDTH{1'b0}};
      result_r  <= {WIDTH{1'b0}};
      idx_r     <= {IDXW{1'b0}};
      carry_r   <= 1'b0;
      op_r      <= 1'b0;
      amsb_r    <= 1'b0;
      cout_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            // Negate is ~A + 1, so invert once here and share the +1 path.
            operand_r <= op ? ~a : a;
            op_r      <= op;
            amsb_r    <= a[WIDTH-1];
            carry_r   <= 1'b1;
            idx_r     <= {IDXW{1'b0}};
            state_r   <= RUN;
          end
        end
        RUN: begin
          result_r[{idx_r, 2'b00} +: 4] <= slice_s[3:0];
          carry_r                       <= slice_s[4];
          if (idx_r == LAST_IDX) begin
            cout_r  <= slice_s[4];
            ovf_r   <= ovf_s;
            idx_r   <= {IDXW{1'b0}};
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Handshake and status decode straight from the state register.
  always_comb begin
    in_ready  = (state_r == IDLE);
    out_valid = (state_r == DONE);
    busy      = (state_r != IDLE);
    result    = result_r;
    cout      = cout_r;
    ovf       = ovf_r;
  end

endmodule

// File: tb/tb_twos_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_twos_serial_ctrl
//   Self-checking bench for twos_serial_ctrl (WIDTH = 32). Expected values come
//   from a word-level arithmetic reference model (A+1 / -A and their flags).
// -----------------------------------------------------------------------------
module tb_twos_serial_ctrl;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  twos_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word-level reference: increment is A+1, negate is 0-A.
  function automatic logic [WIDTH+1:0] ref_model(input logic o, input logic [WIDTH-1:0] av);
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    if (o) begin
      r = 32'd0 - av;
      c = (av == 32'h0000_0000);
      v = (av == 32'h8000_0000);
    end else begin
      r = av + 32'd1;
      c = (av == 32'hFFFF_FFFF);
      v = (av == 32'h7FFF_FFFF);
    end
    return {c, v, r};
  endfunction

  // One full transaction; hold = cycles out_ready stays low in DONE.
  task automatic run_op(input string tag, input logic o, input logic [WIDTH-1:0] av, input int hold);
    logic [WIDTH+1:0] exp;
    logic [WIDTH-1:0] snap;
    int n;
    exp = ref_model(o, av);
    @(negedge clk);
    check({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    op       = o;
    a        = av;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op       = 1'($urandom_range(0, 1));
    a        = $urandom;
    check({tag, ".busy_run"}, {62'd0, busy, in_ready}, 64'd2);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'd8);
    check({tag, ".result"}, {32'd0, result}, {32'd0, exp[WIDTH-1:0]});
    check({tag, ".cout"}, {63'd0, cout}, {63'd0, exp[WIDTH+1]});
    check({tag, ".ovf"}, {63'd0, ovf}, {63'd0, exp[WIDTH]});
    snap = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = 32'h1234_5678;
      op       = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({tag, ".hold_result"}, {32'd0, result}, {32'd0, snap});
      check({tag, ".hold_flags"}, {61'd0, out_valid, in_ready, cout},
            {61'd0, 1'b1, 1'b0, exp[WIDTH+1]});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".to_idle"}, {61'd0, out_valid, in_ready, busy}, 64'd2);
  endtask

  initial begin
    logic [WIDTH+1:0] exp;
    logic [WIDTH-1:0] rv;
    logic             ro;
    int               last_acc;
    int               n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 1'b0;
    a         = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.ctrl", {61'd0, in_ready, out_valid, busy}, 64'd4);
    check("reset.data", {30'd0, cout, ovf, result}, 64'd0);
    rst_n = 1'b1;

    // Directed boundary cases.
    run_op("inc_0f",   1'b0, 32'h0000_000F, 0);
    run_op("inc_ones", 1'b0, 32'hFFFF_FFFF, 1);
    run_op("inc_max",  1'b0, 32'h7FFF_FFFF, 0);
    run_op("neg_one",  1'b1, 32'h0000_0001, 0);
    run_op("neg_zero", 1'b1, 32'h0000_0000, 0);
    run_op("neg_min",  1'b1, 32'h8000_0000, 0);
    run_op("stall5",   1'b0, 32'h0000_00FF, 5);

    // Reset in RUN after nibbles 0..3 have been processed.
    @(negedge clk);
    in_valid = 1'b1;
    op       = 1'b0;
    a        = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.ctrl", {61'd0, out_valid, in_ready, busy}, 64'd2);
    check("abort.data", {30'd0, cout, ovf, result}, 64'd0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("abort.no_valid", 64'(n), 64'd0);
    rst_n = 1'b1;
    run_op("neg_five", 1'b1, 32'h0000_0005, 0);

    // Random operands with random stall, boundary values mixed in.
    for (int k = 0; k < 20; k++) begin
      ro = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       rv = 32'hFFFF_FFFF;
        1:       rv = 32'h7FFF_FFFF;
        2:       rv = 32'h8000_0000;
        3:       rv = 32'h0000_0000;
        default: rv = $urandom;
      endcase
      run_op("rand", ro, rv, $urandom_range(0, 2));
    end

    // Back-to-back: in_valid and out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    last_acc  = 0;
    for (int k = 0; k < 10; k++) begin
      ro = 1'($urandom_range(0, 1));
      rv = $urandom;
      op = ro;
      a  = rv;
      exp = ref_model(ro, rv);
      n = 0;
      while (!in_ready && n < 30) begin
        @(negedge clk);
        n++;
      end
      if (k > 0) check("b2b.interval", 64'(cyc - last_acc), 64'd10);
      last_acc = cyc;
      @(posedge clk);
      @(negedge clk);
      op = 1'($urandom_range(0, 1));
      a  = $urandom;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b2b.result", {30'd0, cout, ovf, result},
            {30'd0, exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0]});
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
